// File: rtl/comparator_monitor.sv
// comparator_monitor: synchronizes and glitch-filters the analog comparator
// output, counts filtered rising/falling edges, and raises a maskable level
// interrupt. All state is visible through a Wishbone slave register window.
//
// Optional feature macro: COMP_MON_TIMESTAMP_EN
//   defined   -> a free-running 32-bit cycle counter (running while en=1) is
//                captured into TSTAMP on every filtered edge.
//   undefined -> TSTAMP reads 0; no counter or capture register is built.
module comparator_monitor #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        comp_i,
  output logic        comp_level_o,
  output logic        irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Control register fields
  logic             en_r;
  logic             ie_rise_r;
  logic             ie_fall_r;
  logic [3:0]       filt_r;

  // Status and counters
  logic             rise_flag_r;
  logic             fall_flag_r;
  logic [CNT_W-1:0] rise_cnt_r;
  logic [CNT_W-1:0] fall_cnt_r;

  // Synchronizer and filter state
  logic             s1_r;
  logic             s2_r;
  logic             level_r;
  logic [3:0]       filt_cnt_r;

  // Bus registers
  logic             ack_r;
  logic [31:0]      dat_r;

  // Decoded bus strobes and combinational helpers
  logic             hit_s;
  logic             req_s;
  logic             wr_s;
  logic [2:0]       word_idx_s;
  logic             ctrl_wr_s;
  logic             status_wr_s;
  logic             rise_clr_s;
  logic             fall_clr_s;
  logic             differ_s;
  logic             settle_s;
  logic             rise_s;
  logic             fall_s;
  logic [31:0]      rdata_s;
  logic [31:0]      tstamp_s;
  logic             unused_s;

  assign hit_s       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign req_s       = hit_s & ~ack_r;
  assign wr_s        = req_s & wbs_we_i;
  assign word_idx_s  = wbs_adr_i[4:2];
  assign ctrl_wr_s   = wr_s & (word_idx_s == 3'd0) & wbs_sel_i[0];
  assign status_wr_s = wr_s & (word_idx_s == 3'd1) & wbs_sel_i[0];
  assign rise_clr_s  = wr_s & (word_idx_s == 3'd2) & wbs_sel_i[0];
  assign fall_clr_s  = wr_s & (word_idx_s == 3'd3) & wbs_sel_i[0];

  // A filtered edge happens when s2 has disagreed with level for filt+1 cycles.
  assign differ_s    = s2_r ^ level_r;
  assign settle_s    = differ_s & (filt_cnt_r == filt_r);
  assign rise_s      = en_r & settle_s & s2_r;
  assign fall_s      = en_r & settle_s & ~s2_r;

  assign wbs_ack_o    = ack_r;
  assign wbs_dat_o    = dat_r;
  assign comp_level_o = level_r;
  assign irq_o        = en_r & ((rise_flag_r & ie_rise_r) | (fall_flag_r & ie_fall_r));

  // Only byte 0 of the data bus carries fields; the rest is deliberately ignored.
  assign unused_s = ^{wbs_dat_i[31:8], wbs_sel_i[3:1], wbs_adr_i[1:0]};

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= comp_i;
      s2_r <= s1_r;
    end
  end

  // Glitch filter; while disabled, level tracks s2 so re-enable cannot create an edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      level_r    <= 1'b0;
      filt_cnt_r <= 4'd0;
    end else if (!en_r) begin
      level_r    <= s2_r;
      filt_cnt_r <= 4'd0;
    end else if (differ_s) begin
      if (filt_cnt_r == filt_r) begin
        level_r    <= s2_r;
        filt_cnt_r <= 4'd0;
      end else begin
        filt_cnt_r <= filt_cnt_r + 4'd1;
      end
    end else begin
      filt_cnt_r <= 4'd0;
    end
  end

  // CTRL register, byte-lane 0 holds every field.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en_r      <= 1'b0;
      ie_rise_r <= 1'b0;
      ie_fall_r <= 1'b0;
      filt_r    <= 4'd0;
    end else if (ctrl_wr_s) begin
      en_r      <= wbs_dat_i[0];
      ie_rise_r <= wbs_dat_i[1];
      ie_fall_r <= wbs_dat_i[2];
      filt_r    <= wbs_dat_i[7:4];
    end
  end

  // Sticky edge flags; a new edge takes priority over a write-one-to-clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rise_flag_r <= 1'b0;
      fall_flag_r <= 1'b0;
    end else begin
      if (rise_s) begin
        rise_flag_r <= 1'b1;
      end else if (status_wr_s && wbs_dat_i[1]) begin
        rise_flag_r <= 1'b0;
      end
      if (fall_s) begin
        fall_flag_r <= 1'b1;
      end else if (status_wr_s && wbs_dat_i[2]) begin
        fall_flag_r <= 1'b0;
      end
    end
  end

  // Saturating edge counters; clear plus increment in one cycle leaves 1.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rise_cnt_r <= '0;
      fall_cnt_r <= '0;
    end else begin
      if (rise_clr_s) begin
        rise_cnt_r <= rise_s ? CNT_ONE : '0;
      end else if (rise_s && (rise_cnt_r != CNT_MAX)) begin
        rise_cnt_r <= rise_cnt_r + CNT_ONE;
      end
      if (fall_clr_s) begin
        fall_cnt_r <= fall_s ? CNT_ONE : '0;
      end else if (fall_s && (fall_cnt_r != CNT_MAX)) begin
        fall_cnt_r <= fall_cnt_r + CNT_ONE;
      end
    end
  end

`ifdef COMP_MON_TIMESTAMP_EN
  logic [31:0] ts_cnt_r;
  logic [31:0] tstamp_r;

  // Free-running cycle counter (while enabled) and capture on every filtered edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ts_cnt_r <= 32'd0;
      tstamp_r <= 32'd0;
    end else begin
      if (en_r) begin
        ts_cnt_r <= ts_cnt_r + 32'd1;
      end
      if (rise_s || fall_s) begin
        tstamp_r <= ts_cnt_r;
      end
    end
  end

  assign tstamp_s = tstamp_r;
`else
  assign tstamp_s = 32'd0;
`endif

  // Read-data multiplexer over the eight-word window.
  always_comb begin
    rdata_s = 32'd0;
    case (word_idx_s)
      3'd0:    rdata_s = {24'd0, filt_r, 1'b0, ie_fall_r, ie_rise_r, en_r};
      3'd1:    rdata_s = {29'd0, fall_flag_r, rise_flag_r, level_r};
      3'd2:    rdata_s = 32'(rise_cnt_r);
      3'd3:    rdata_s = 32'(fall_cnt_r);
      3'd4:    rdata_s = tstamp_s;
      default: rdata_s = 32'd0;
    endcase
  end

  // Single-cycle acknowledge with registered read data, zero outside ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= req_s;
      dat_r <= req_s ? rdata_s : 32'd0;
    end
  end

endmodule

// File: doc/comparator_monitor.md
# comparator_monitor

Digital readback block for the on-chip analog comparator. It synchronizes the comparator's asynchronous output and removes glitches with a programmable filter. It counts rising and falling edges and raises a maskable interrupt, with all state exposed to the management SoC over the Wishbone slave port of the user analog project wrapper.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: register window base; decoded on wbs_adr_i[31:5].
- CNT_W, 16: edge counter width (1..32).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte lane enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- comp_i  in  1  raw comparator output (asynchronous).
- comp_level_o  out  1  filtered comparator level.
- irq_o  out  1  interrupt, level, active-high.

## Operation
- Register map, word index wbs_adr_i[4:2]:
  - 0 CTRL (RW): [0] en, [1] ie_rise, [2] ie_fall, [7:4] filt.
  - 1 STATUS: [0] level (RO), [1] rise_flag (W1C), [2] fall_flag (W1C).
  - 2 RISE_CNT (RO; any write clears it).
  - 3 FALL_CNT (RO; any write clears it).
  - 4 TSTAMP (RO).
  - 5–7: read 0, writes ignored.
- Byte lane rules:
  - CTRL writes honor wbs_sel_i per byte.
  - STATUS and count-clear writes take effect only when wbs_sel_i[0]=1.
- Synchronizer: two flops, s1 then s2.
- Glitch filter:
  - The filter counter increments each cycle that s2 ≠ level, and clears when they agree.
  - When the counter equals filt, level takes the value of s2 and the counter clears.
- Rising edge (level 0→1): rise_flag set; RISE_CNT increments, saturating at all ones. Falling edge (1→0) does the same with fall_flag and FALL_CNT.
- irq_o = en & ((rise_flag & ie_rise) | (fall_flag & ie_fall)), combinational from registered bits.
- en=0:
  - Filter counter is held at 0.
  - level loads s2 every cycle, generating no edges.
  - Counters and flags hold their values.
  - Re-enabling therefore never produces a spurious edge.
- Simultaneous events:
  - A flag set and a W1C of that flag in the same cycle: the set wins.
  - An increment and a clear of the same counter in the same cycle: the result is 1.

## Timing
- Reset values: all registers 0, level 0, filter counter 0, wbs_ack_o 0, wbs_dat_o 0, irq_o 0, comp_level_o 0.
- Wishbone handshake:
  - When stb & cyc & address match & !ack, wbs_ack_o asserts on the next edge, for exactly one cycle.
  - Minimum 2 cycles per transfer.
  - Write side effects occur on the same edge that ack asserts.
  - wbs_dat_o is valid while ack is high and is 0 otherwise.
- comp_i latency: if comp_i changes before edge k and is stable, s2 holds the new value after edge k+1, and level/comp_level_o update at edge k+2+filt. Flags, counters and TSTAMP update on that same edge; irq_o follows combinationally.
- Pulse rejection: a comp_i pulse shorter than filt+1 cycles, as seen at s2, is rejected.
- Reset mid-operation: wb_rst_i clears everything on the next edge, including an in-flight ack.

## Configuration
- COMP_MON_TIMESTAMP_EN defined:
  - A 32-bit free-running counter increments every cycle while en=1 and wraps from 0xFFFF_FFFF to 0.
  - Each filtered edge captures the counter value into TSTAMP.
- Undefined: TSTAMP reads 0 and neither the counter nor the capture register is built.

## Test plan
- Reset, then read all 8 words → every read returns 0, each ack is a single cycle, and irq_o=0.
- CTRL=0x0000_0007, comp_i 0→1 held → comp_level_o=1 at k+2, rise_flag=1, RISE_CNT=1, irq_o=1. W1C STATUS=0x2 → irq_o=0.
- filt=3, 3-cycle high pulse on comp_i → no level change and RISE_CNT=0. A 4-cycle pulse → RISE_CNT=1 and FALL_CNT=1.
- 0xFFFF rising edges with CNT_W=16, then one more → RISE_CNT stays at 0xFFFF.
- Rising edge landing in the same cycle as a write to RISE_CNT → RISE_CNT=1. Rising edge landing in the same cycle as a W1C of rise_flag → rise_flag=1.
- With COMP_MON_TIMESTAMP_EN: en set at cycle 0, edge detected 100 cycles later → TSTAMP=100 ± 1 per the capture edge. Without the macro → TSTAMP=0.
